arbitrate: RTL and testbench

- Round-robin N-to-1 merge stage. It collects the fan-out channels produced by the demultiplexing stage, or any set of stb/dat/rdy producers, onto a single registered output stream.
- The output carries the originating channel index, so a downstream demultiplexer can route replies back.
- Bursts marked with a last flag are kept contiguous by locking the grant until the last beat is accepted.

---
 rtl/arbitrate_pkg.sv | 14 +
 rtl/arbitrate_rr_pick.sv | 32 +++
 rtl/arbitrate.sv | 122 ++++++++++++
 tb/tb_arbitrate.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arbitrate_pkg.sv
// Shared types and helpers for the arbitrate merge stage and its sibling demux.
package arbitrate_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Channel-index width; never below one bit so single-channel sel/idx buses stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitrate_rr_pick.sv
// Combinational rotate-priority encoder: first requester at or after i_ptr, wrapping.
module rr_pick
  import arbitrate_pkg::*;
#(
  parameter int unsigned  INC = 2,
  localparam int unsigned IW  = idx_w(INC)
) (
  input  logic [INC-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [IW-1:0]  o_gnt,
  output logic           o_vld
);

  // Smallest rotated distance from i_ptr wins.
  always_comb begin
    int unsigned w_best;
    int unsigned w_dist;
    o_gnt  = '0;
    w_best = INC;
    w_dist = 0;
    for (int unsigned i = 0; i < INC; i++) begin
      w_dist = (i + INC - 32'(i_ptr)) % INC;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_gnt  = IW'(i);
      end
    end
  end

  assign o_vld = |i_req;

endmodule

// File: rtl/arbitrate.sv
// Round-robin N-to-1 merge onto a one-entry registered output, with burst locking on in_lst.
module arbitrate
  import arbitrate_pkg::*;
#(
  parameter int unsigned  ARGW = 16,
  parameter int unsigned  INC  = 2,
  localparam int unsigned IW   = idx_w(INC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INC-1:0]      in_stb,
  input  logic [INC*ARGW-1:0] in_dat,
  input  logic [INC-1:0]      in_lst,
  output logic [INC-1:0]      in_rdy,
  output logic                out_stb,
  output logic [ARGW-1:0]     out_dat,
  output logic [IW-1:0]       out_idx,
  output logic                out_lst,
  input  logic                out_rdy
);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_lck_idx;
  logic            r_out_stb;
  logic [ARGW-1:0] r_out_dat;
  logic [IW-1:0]   r_out_idx;
  logic            r_out_lst;

  logic [IW-1:0]   w_rr_gnt;
  logic            w_rr_vld;
  logic [IW-1:0]   w_gnt;
  logic            w_vld;
  logic            w_free;
  logic            w_acc;
  logic [INC-1:0]  w_rdy;
  logic [ARGW-1:0] w_dat;
  logic            w_lst;
  logic [IW-1:0]   w_ptr_nxt;

  rr_pick #(.INC(INC)) u_pick (
    .i_req (in_stb),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_vld (w_rr_vld)
  );

  // Held reset also blocks acceptance so nothing is taken while the stage is cleared.
  assign w_free = rst & (~r_out_stb | out_rdy);
  assign w_acc  = w_vld & w_free;

  always_comb begin
    w_gnt = w_rr_gnt;
    w_vld = w_rr_vld;
    if (r_state == LOCK) begin
      w_gnt = r_lck_idx;
      w_vld = 1'b0;
      for (int unsigned i = 0; i < INC; i++) begin
        if (r_lck_idx == IW'(i)) w_vld = in_stb[i];
      end
    end
  end

  // Route the granted channel's payload and build the one-hot accept.
  always_comb begin
    w_rdy = '0;
    w_dat = '0;
    w_lst = 1'b0;
    for (int unsigned i = 0; i < INC; i++) begin
      if (w_gnt == IW'(i)) begin
        w_rdy[i] = w_acc;
        w_dat    = in_dat[ARGW*i +: ARGW];
        w_lst    = in_lst[i];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == IW'(INC - 1)) ? '0 : w_gnt + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_lck_idx <= '0;
      r_out_stb <= 1'b0;
      r_out_dat <= '0;
      r_out_idx <= '0;
      r_out_lst <= 1'b0;
    end else begin
      if (w_acc) begin
        r_out_stb <= 1'b1;
        r_out_dat <= w_dat;
        r_out_idx <= w_gnt;
        r_out_lst <= w_lst;
      end else if (out_rdy) begin
        r_out_stb <= 1'b0;
      end

      if (w_acc && w_lst) r_ptr <= w_ptr_nxt;

      case (r_state)
        IDLE: begin
          if (w_acc && !w_lst) begin
            r_state   <= LOCK;
            r_lck_idx <= w_gnt;
          end
        end
        LOCK: begin
          if (w_acc && w_lst) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_rdy  = w_rdy;
  assign out_stb = r_out_stb;
  assign out_dat = r_out_dat;
  assign out_idx = r_out_idx;
  assign out_lst = r_out_lst;

endmodule

// File: tb/tb_arbitrate.sv
// Directed scoreboard bench for arbitrate with a 2-channel and a 4-channel instance.
module tb_arbitrate;

  typedef struct {
    logic [15:0] dat;
    logic [1:0]  idx;
    logic        lst;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ordy;
  logic [15:0] dat [4];

  logic [1:0]  stb2, lst2, rdy2;
  logic [31:0] idat2;
  logic        ostb2, olst2;
  logic [15:0] odat2;
  logic [0:0]  oidx2;

  logic [3:0]  stb4, lst4, rdy4;
  logic [63:0] idat4;
  logic        ostb4, olst4;
  logic [15:0] odat4;
  logic [1:0]  oidx4;

  int checks = 0;
  int errors = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  assign idat2 = {dat[1], dat[0]};
  assign idat4 = {dat[3], dat[2], dat[1], dat[0]};

  arbitrate #(.ARGW(16), .INC(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_stb(stb2), .in_dat(idat2), .in_lst(lst2), .in_rdy(rdy2),
    .out_stb(ostb2), .out_dat(odat2), .out_idx(oidx2), .out_lst(olst2),
    .out_rdy(ordy)
  );

  arbitrate #(.ARGW(16), .INC(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_stb(stb4), .in_dat(idat4), .in_lst(lst4), .in_rdy(rdy4),
    .out_stb(ostb4), .out_dat(odat4), .out_idx(oidx4), .out_lst(olst4),
    .out_rdy(ordy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check accept, update scoreboard, then check the registered output.
  task automatic cyc(input bit u4, input logic [3:0] stb, input logic [3:0] lst,
                     input logic rdy, input logic [3:0] exp_rdy, input string tag);
    beat_t b;
    stb2 = u4 ? 2'b00 : stb[1:0];
    stb4 = u4 ? stb : 4'b0000;
    lst2 = lst[1:0];
    lst4 = lst;
    ordy = rdy;
    #1;
    chk({tag, "/in_rdy"}, u4 ? 32'(rdy4) : 32'(rdy2), 32'(exp_rdy));
    if (rdy && (q.size() > 0)) void'(q.pop_front());
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        b.dat = dat[i];
        b.idx = 2'(i);
        b.lst = lst[i];
        q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "/out_stb"}, 32'(u4 ? ostb4 : ostb2), 32'(q.size() != 0));
    if (q.size() > 0) begin
      chk({tag, "/out_dat"}, 32'(u4 ? odat4 : odat2), 32'(q[0].dat));
      chk({tag, "/out_idx"}, u4 ? 32'(oidx4) : 32'(oidx2), 32'(q[0].idx));
      chk({tag, "/out_lst"}, 32'(u4 ? olst4 : olst2), 32'(q[0].lst));
    end
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b0;
    ordy   = 1'b1;
    stb2   = 2'b11;
    lst2   = 2'b11;
    stb4   = 4'b0000;
    lst4   = 4'b0000;
    dat[0] = 16'hAAAA;
    dat[1] = 16'h5555;
    dat[2] = 16'h2222;
    dat[3] = 16'h3333;

    // Reset held with both channels requesting
    #3;
    chk("rst/out_stb", 32'(ostb2), 32'd0);
    chk("rst/in_rdy", 32'(rdy2), 32'd0);
    chk("rst/out_dat", 32'(odat2), 32'd0);
    chk("rst/out_idx", 32'(oidx2), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Fairness: single-beat bursts alternate 0,1,0,1
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0001, "fair0");
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0010, "fair1");
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0001, "fair2");
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0010, "fair3");
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, "drain0");

    // Burst lock on ch0 while ch1 keeps requesting, including an idle gap in ch0
    dat[0] = 16'h0001;
    cyc(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, "burst1");
    dat[0] = 16'h0002;
    cyc(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, "burst2");
    cyc(1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000, "lockgap");
    dat[0] = 16'h0003;
    cyc(1'b0, 4'b0011, 4'b0001, 1'b1, 4'b0001, "burst3");
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0010, "after_lock");

    // Backpressure: ch1 beat held four cycles, then ch0 follows without loss
    dat[0] = 16'hC0DE;
    for (int k = 0; k < 4; k++) cyc(1'b0, 4'b0011, 4'b0011, 1'b0, 4'b0000, "bp_hold");
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0001, "bp_release");
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, "drain1");

    // Lock onto ch1, then reset asynchronously mid-burst
    dat[1] = 16'hBEEF;
    cyc(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, "lock_ch1");
    rst = 1'b0;
    #1;
    chk("async_rst/out_stb", 32'(ostb2), 32'd0);
    chk("async_rst/in_rdy", 32'(rdy2), 32'd0);
    q.delete();
    #1 rst = 1'b1;
    dat[0] = 16'h1234;
    cyc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0001, "post_rst_tie");
    cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, "drain2");

    // Wrap with four channels: ptr moved to 2, then ch3/ch1 alternate
    dat[1] = 16'h1111;
    dat[3] = 16'h3333;
    cyc(1'b1, 4'b0010, 4'b1111, 1'b1, 4'b0010, "wrap_setup");
    cyc(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b1000, "wrap_a");
    cyc(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010, "wrap_b");
    cyc(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b1000, "wrap_c");
    cyc(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010, "wrap_d");
    cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, "drain3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
